// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: opcode map, field offsets, ID/EX control bundle
// and the opcode-to-control decoder used by the decode stage.
package decode_pkg;

  // Instruction layout: [4:0] opcode, then rd, rs1, rs2 of RA_W bits each.
  localparam int unsigned OpcodeW   = 5;
  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned RdLsb     = OpcodeW;

  localparam logic [OpcodeW-1:0] OpAdd  = 5'h00;
  localparam logic [OpcodeW-1:0] OpSub  = 5'h01;
  localparam logic [OpcodeW-1:0] OpAnd  = 5'h02;
  localparam logic [OpcodeW-1:0] OpOr   = 5'h03;
  localparam logic [OpcodeW-1:0] OpSlt  = 5'h04;
  localparam logic [OpcodeW-1:0] OpAddi = 5'h08;
  localparam logic [OpcodeW-1:0] OpLw   = 5'h10;
  localparam logic [OpcodeW-1:0] OpSw   = 5'h11;
  localparam logic [OpcodeW-1:0] OpBeq  = 5'h18;
  localparam logic [OpcodeW-1:0] OpJal  = 5'h1B;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] ResAlu = 2'b00;
  localparam logic [1:0] ResMem = 2'b01;
  localparam logic [1:0] ResPc4 = 2'b10;

  typedef enum logic [1:0] {ImmI, ImmS, ImmB, ImmJ} imm_src_e;

  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic       ALUSrc;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_BUBBLE = '0;

  typedef struct packed {
    idex_ctrl_t ctrl;
    imm_src_e   imm_src;
  } ctrl_dec_t;

  // Unknown opcodes decode to a bubble so they never write state.
  function automatic ctrl_dec_t control_unit(input logic [OpcodeW-1:0] op);
    ctrl_dec_t d;
    d.ctrl    = IDEX_BUBBLE;
    d.imm_src = ImmI;
    case (op)
      OpAdd:  begin d.ctrl.RegWrite = 1'b1; d.ctrl.ALUControl = AluAdd; end
      OpSub:  begin d.ctrl.RegWrite = 1'b1; d.ctrl.ALUControl = AluSub; end
      OpAnd:  begin d.ctrl.RegWrite = 1'b1; d.ctrl.ALUControl = AluAnd; end
      OpOr:   begin d.ctrl.RegWrite = 1'b1; d.ctrl.ALUControl = AluOr;  end
      OpSlt:  begin d.ctrl.RegWrite = 1'b1; d.ctrl.ALUControl = AluSlt; end
      OpAddi: begin
        d.ctrl.RegWrite = 1'b1;
        d.ctrl.ALUSrc   = 1'b1;
      end
      OpLw: begin
        d.ctrl.RegWrite  = 1'b1;
        d.ctrl.ALUSrc    = 1'b1;
        d.ctrl.ResultSrc = ResMem;
      end
      OpSw: begin
        d.ctrl.MemWrite = 1'b1;
        d.ctrl.ALUSrc   = 1'b1;
        d.imm_src       = ImmS;
      end
      OpBeq: begin
        d.ctrl.Branch     = 1'b1;
        d.ctrl.ALUControl = AluSub;
        d.imm_src         = ImmB;
      end
      OpJal: begin
        d.ctrl.RegWrite  = 1'b1;
        d.ctrl.Jump      = 1'b1;
        d.ctrl.ResultSrc = ResPc4;
        d.imm_src        = ImmJ;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_hz_regfile_bypass.sv
// Register file with async clear, out-of-range masking and write-through bypass.
module regfile_bypass
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 19,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned NUM_REGS = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr1,
  input  logic [RA_W-1:0]   raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              w_ok;

  assign w_ok = we && (32'(waddr) < NUM_REGS);

  // Storage: cleared by reset, written only for implemented addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_ok) begin
      regs_q[waddr[IdxW-1:0]] <= wdata;
    end
  end

  // Reads: unimplemented addresses return 0; a same-cycle write wins.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (32'(raddr1) < NUM_REGS) rdata1 = regs_q[raddr1[IdxW-1:0]];
    if (32'(raddr2) < NUM_REGS) rdata2 = regs_q[raddr2[IdxW-1:0]];
    if (w_ok && (waddr == raddr1)) rdata1 = wdata;
    if (w_ok && (waddr == raddr2)) rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage and ID/EX pipeline register with stall, flush and valid tracking.
module decode_stage_hz
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 19,
  parameter int unsigned PC_W     = 15,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned NUM_REGS = 19,
  localparam int unsigned INSTR_W = OpcodeW + 3 * RA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallD,
  input  logic               FlushE,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [PC_W-1:0]    PCD,
  input  logic               RegWriteW,
  input  logic [RA_W-1:0]    RdW,
  input  logic [DATA_W-1:0]  ResultW,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               JumpE,
  output logic               BranchE,
  output logic               ALUSrcE,
  output logic [1:0]         ResultSrcE,
  output logic [2:0]         ALUControlE,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [PC_W-1:0]    PCE,
  output logic [RA_W-1:0]    RDE,
  output logic [RA_W-1:0]    RS1E,
  output logic [RA_W-1:0]    RS2E,
  output logic               ValidE
);

  logic [OpcodeW-1:0] opcode;
  logic [RA_W-1:0]    rd_f, rs1_f, rs2_f;
  ctrl_dec_t          dec;
  logic [DATA_W-1:0]  rd1_d, rd2_d, imm_ext;

  idex_ctrl_t        ctrl_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
  logic [PC_W-1:0]   pc_q;
  logic [RA_W-1:0]   rd_q, rs1_q, rs2_q;
  logic              valid_q;

  assign opcode = InstrD[OpcodeLsb +: OpcodeW];
  assign rd_f   = InstrD[RdLsb +: RA_W];
  assign rs1_f  = InstrD[RdLsb + RA_W +: RA_W];
  assign rs2_f  = InstrD[RdLsb + 2 * RA_W +: RA_W];
  assign dec    = control_unit(opcode);

  regfile_bypass #(
    .DATA_W  (DATA_W),
    .RA_W    (RA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (RegWriteW),
    .waddr (RdW),
    .wdata (ResultW),
    .raddr1(rs1_f),
    .raddr2(rs2_f),
    .rdata1(rd1_d),
    .rdata2(rd2_d)
  );

  // Immediate extension over InstrD[INSTR_W-1:5]; B and J immediates are halfword offsets.
  always_comb begin
    imm_ext = '0;
    unique case (dec.imm_src)
      ImmI: imm_ext = DATA_W'($signed(rs2_f));
      ImmS: imm_ext = DATA_W'($signed({rs2_f, rd_f}));
      ImmB: imm_ext = DATA_W'($signed({rs2_f, rd_f, 1'b0}));
      ImmJ: imm_ext = DATA_W'($signed({rs2_f, rs1_f, rd_f, 1'b0}));
    endcase
  end

  // ID/EX register: flush beats stall; stall holds the captured operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || FlushE) begin
      ctrl_q  <= IDEX_BUBBLE;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      valid_q <= 1'b0;
    end else if (!StallD) begin
      ctrl_q  <= dec.ctrl;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_ext;
      pc_q    <= PCD;
      rd_q    <= rd_f;
      rs1_q   <= rs1_f;
      rs2_q   <= rs2_f;
      valid_q <= 1'b1;
    end
  end

  assign RegWriteE   = ctrl_q.RegWrite;
  assign MemWriteE   = ctrl_q.MemWrite;
  assign JumpE       = ctrl_q.Jump;
  assign BranchE     = ctrl_q.Branch;
  assign ALUSrcE     = ctrl_q.ALUSrc;
  assign ResultSrcE  = ctrl_q.ResultSrc;
  assign ALUControlE = ctrl_q.ALUControl;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = imm_q;
  assign PCE         = pc_q;
  assign RDE         = rd_q;
  assign RS1E        = rs1_q;
  assign RS2E        = rs2_q;
  assign ValidE      = valid_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: vector table plus stall, flush and reset sequences.
module tb_decode_stage_hz;

  // Opcode map and expected control words {RegWrite,MemWrite,Jump,Branch,ALUSrc,ResultSrc,ALUCtl}.
  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01, OP_AND = 5'h02, OP_OR = 5'h03;
  localparam logic [4:0] OP_ADDI = 5'h08, OP_LW = 5'h10, OP_SW = 5'h11;
  localparam logic [4:0] OP_BEQ = 5'h18, OP_JAL = 5'h1B, OP_BAD = 5'h1F;
  localparam logic [9:0] C_ADD  = 10'b1_0_0_0_0_00_000;
  localparam logic [9:0] C_SUB  = 10'b1_0_0_0_0_00_001;
  localparam logic [9:0] C_AND  = 10'b1_0_0_0_0_00_010;
  localparam logic [9:0] C_OR   = 10'b1_0_0_0_0_00_011;
  localparam logic [9:0] C_ADDI = 10'b1_0_0_0_1_00_000;
  localparam logic [9:0] C_LW   = 10'b1_0_0_0_1_01_000;
  localparam logic [9:0] C_SW   = 10'b0_1_0_0_1_00_000;
  localparam logic [9:0] C_BEQ  = 10'b0_0_0_1_0_00_001;
  localparam logic [9:0] C_JAL  = 10'b1_0_1_0_0_10_000;
  localparam logic [9:0] C_NONE = 10'b0;

  logic        clk, reset, StallD, FlushE, RegWriteW;
  logic [19:0] InstrD;
  logic [14:0] PCD, PCE;
  logic [4:0]  RdW, RDE, RS1E, RS2E;
  logic [18:0] ResultW, RD1E, RD2E, ImmExtE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  int n_checks = 0;
  int n_err    = 0;

  decode_stage_hz dut (
    .clk        (clk),
    .reset      (reset),
    .StallD     (StallD),
    .FlushE     (FlushE),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .JumpE      (JumpE),
    .BranchE    (BranchE),
    .ALUSrcE    (ALUSrcE),
    .ResultSrcE (ResultSrcE),
    .ALUControlE(ALUControlE),
    .RD1E       (RD1E),
    .RD2E       (RD2E),
    .ImmExtE    (ImmExtE),
    .PCE        (PCE),
    .RDE        (RDE),
    .RS1E       (RS1E),
    .RS2E       (RS2E),
    .ValidE     (ValidE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        stall, flush, we;
    logic [4:0]  rdw;
    logic [18:0] resw;
    logic [4:0]  op, rd, rs1, rs2;
    logic [14:0] pc;
    logic [9:0]  exp_ctrl;
    logic        exp_valid, chk_data;
    logic [18:0] exp_rd1, exp_rd2, exp_imm;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_now();
    return {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stall, input logic flush, input logic we, input logic [4:0] rdw,
                       input logic [18:0] resw, input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [14:0] pc);
    StallD = stall; FlushE = flush; RegWriteW = we; RdW = rdw; ResultW = resw;
    InstrD = {rs2, rs1, rd, op}; PCD = pc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctrl"}, 32'(ctrl_now()), 32'd0);
    check({tag, " RD1E"}, 32'(RD1E), 32'd0);
    check({tag, " RD2E"}, 32'(RD2E), 32'd0);
    check({tag, " ImmExtE"}, 32'(ImmExtE), 32'd0);
    check({tag, " PCE"}, 32'(PCE), 32'd0);
    check({tag, " RDE"}, 32'(RDE), 32'd0);
    check({tag, " RS1E"}, 32'(RS1E), 32'd0);
    check({tag, " RS2E"}, 32'(RS2E), 32'd0);
    check({tag, " ValidE"}, 32'(ValidE), 32'd0);
  endtask

  initial begin
    // stall flush we rdw resw op rd rs1 rs2 pc ctrl valid chk rd1 rd2 imm
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 5'd3, 19'h1ABCD, OP_ADD, 5'd1, 5'd0, 5'd0, 15'h1,
                 C_ADD, 1'b1, 1'b1, 19'h0, 19'h0, 19'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd7, 19'h12345, OP_SUB, 5'd2, 5'd3, 5'd3, 15'h2,
                 C_SUB, 1'b1, 1'b1, 19'h1ABCD, 19'h1ABCD, 19'h3};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd7, 19'h00055, OP_ADDI, 5'd4, 5'd7, 5'h1F, 15'h3,
                 C_ADDI, 1'b1, 1'b1, 19'h00055, 19'h0, 19'h7FFFF};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd9, 19'h2AAAA, OP_AND, 5'd5, 5'd9, 5'd9, 15'h4,
                 C_AND, 1'b1, 1'b1, 19'h2AAAA, 19'h2AAAA, 19'h9};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd20, 19'h7FFFF, OP_OR, 5'd6, 5'd20, 5'd7, 15'h5,
                 C_OR, 1'b1, 1'b1, 19'h0, 19'h00055, 19'h7};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd0, 19'h0, OP_LW, 5'd8, 5'd3, 5'h10, 15'h6,
                 C_LW, 1'b1, 1'b1, 19'h1ABCD, 19'h0, 19'h7FFF0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd0, 19'h0, OP_SW, 5'd1, 5'd7, 5'd2, 15'h7,
                 C_SW, 1'b1, 1'b1, 19'h00055, 19'h0, 19'h00041};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'd0, 19'h0, OP_BEQ, 5'h1E, 5'd9, 5'd3, 15'h8,
                 C_BEQ, 1'b1, 1'b1, 19'h2AAAA, 19'h1ABCD, 19'h000FC};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 5'd0, 19'h0, OP_JAL, 5'd1, 5'h1F, 5'h1F, 15'h9,
                 C_JAL, 1'b1, 1'b1, 19'h0, 19'h0, 19'h7FFC2};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 5'd0, 19'h0, OP_ADD, 5'd1, 5'd3, 5'd3, 15'hA,
                 C_NONE, 1'b0, 1'b0, 19'h0, 19'h0, 19'h0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 5'd0, 19'h0, OP_BAD, 5'd3, 5'd3, 5'd3, 15'hB,
                 C_NONE, 1'b1, 1'b1, 19'h1ABCD, 19'h1ABCD, 19'h3};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 5'd18, 19'h3C3C3, OP_ADD, 5'd0, 5'd18, 5'd4, 15'hC,
                 C_ADD, 1'b1, 1'b1, 19'h3C3C3, 19'h0, 19'h4};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 5'd0, 19'h0, OP_ADD, 5'd0, 5'd18, 5'd20, 15'hD,
                 C_ADD, 1'b1, 1'b1, 19'h3C3C3, 19'h0, 19'h7FFF4};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 19'h0, OP_ADD, 5'd0, 5'd0, 5'd0, 15'h0);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].we, vecs[i].rdw, vecs[i].resw,
            vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].pc);
      step();
      check($sformatf("v%0d ctrl", i), 32'(ctrl_now()), 32'(vecs[i].exp_ctrl));
      check($sformatf("v%0d ValidE", i), 32'(ValidE), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d RD1E", i), 32'(RD1E), 32'(vecs[i].exp_rd1));
        check($sformatf("v%0d RD2E", i), 32'(RD2E), 32'(vecs[i].exp_rd2));
        check($sformatf("v%0d ImmExtE", i), 32'(ImmExtE), 32'(vecs[i].exp_imm));
        check($sformatf("v%0d PCE", i), 32'(PCE), 32'(vecs[i].pc));
        check($sformatf("v%0d RDE", i), 32'(RDE), 32'(vecs[i].rd));
        check($sformatf("v%0d RS1E", i), 32'(RS1E), 32'(vecs[i].rs1));
        check($sformatf("v%0d RS2E", i), 32'(RS2E), 32'(vecs[i].rs2));
      end
    end

    // Stall: A captures a bypassed R7; later R7 writes must not leak into the held RD1E.
    drive(1'b0, 1'b0, 1'b1, 5'd7, 19'h11111, OP_ADD, 5'd1, 5'd7, 5'd3, 15'h0010);
    step();
    check("stallA PCE", 32'(PCE), 32'h10);
    check("stallA RD1E", 32'(RD1E), 32'h11111);
    drive(1'b1, 1'b0, 1'b1, 5'd7, 19'h22222, OP_SUB, 5'd2, 5'd9, 5'd9, 15'h0011);
    for (int k = 0; k < 3; k++) begin
      step();
      RegWriteW = 1'b0;
      check($sformatf("stall%0d PCE", k), 32'(PCE), 32'h10);
      check($sformatf("stall%0d ValidE", k), 32'(ValidE), 32'd1);
      check($sformatf("stall%0d RD1E", k), 32'(RD1E), 32'h11111);
      check($sformatf("stall%0d ALUControlE", k), 32'(ALUControlE), 32'd0);
    end
    StallD = 1'b0;
    step();
    check("unstall PCE", 32'(PCE), 32'h11);
    check("unstall RD1E", 32'(RD1E), 32'h2AAAA);
    check("unstall ALUControlE", 32'(ALUControlE), 32'd1);

    // Flush on its own, then a normal load.
    drive(1'b0, 1'b1, 1'b0, 5'd0, 19'h0, OP_JAL, 5'd1, 5'd0, 5'd0, 15'h0012);
    step();
    check("flush ctrl", 32'(ctrl_now()), 32'd0);
    check("flush ValidE", 32'(ValidE), 32'd0);
    FlushE = 1'b0;
    step();
    check("postflush ctrl", 32'(ctrl_now()), 32'(C_JAL));
    check("postflush ValidE", 32'(ValidE), 32'd1);
    check("postflush PCE", 32'(PCE), 32'h12);

    // Asynchronous reset between clock edges, then every register must read back 0.
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 19; r++) begin
      drive(1'b0, 1'b0, 1'b0, 5'd0, 19'h0, OP_ADD, 5'd0, 5'(r), 5'(r), 15'h0);
      step();
      check($sformatf("clr R%0d RD1E", r), 32'(RD1E), 32'd0);
      check($sformatf("clr R%0d RD2E", r), 32'(RD2E), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
